// File: rtl/pll_lock_seq.sv
// rtl/pll_lock_seq.sv - PLL reset sequencer and frequency lock monitor (optional irq via PLL_LOCK_SEQ_IRQ_EN)
module pll_lock_seq #(
    parameter int WIN_CYC    = 64,
    parameter int CW         = 8,
    parameter int TOL        = 2,
    parameter int RST_CYC    = 16,
    parameter int SETTLE_CYC = 256,
    parameter int GOOD_REQ   = 4,
    parameter int BAD_REQ    = 2,
    parameter int RETRY_MAX  = 3
) (
    input  logic          ref_clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CW-1:0] exp_cnt,
    input  logic          fb_tgl,
    output logic          pll_rst,
    output logic          locked,
    output logic          fault,
    output logic          busy,
    output logic [CW-1:0] meas_cnt,
    output logic [1:0]    retry_cnt
`ifdef PLL_LOCK_SEQ_IRQ_EN
    ,
    output logic          irq,
    input  logic          irq_clr
`endif
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RESET   = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_MEASURE = 3'd3;
    localparam logic [2:0] ST_LOCKED  = 3'd4;
    localparam logic [2:0] ST_FAULT   = 3'd5;

    localparam int TW = $clog2((SETTLE_CYC > RST_CYC) ? SETTLE_CYC : RST_CYC) + 1;
    localparam int WW = $clog2(WIN_CYC) + 1;
    localparam int GW = $clog2(GOOD_REQ) + 1;
    localparam int BW = $clog2(BAD_REQ) + 1;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [TW-1:0]     seq_cnt;
    logic [WW-1:0]     win_cnt;
    logic [CW-1:0]     edge_cnt;
    logic [CW-1:0]     cnt_fin;
    logic [CW-1:0]     exp_q;
    logic [GW-1:0]     good_run;
    logic [BW-1:0]     bad_run;
    logic              sync1;
    logic              sync2;
    logic              sync3;
    logic              edge_det;
    logic              in_win;
    logic              win_end;
    logic signed [CW:0] diff;
    logic [CW:0]       mag;
    logic              good;
    logic              good_last;
    logic              bad_last;
    logic              retry_last;

    assign edge_det   = sync2 ^ sync3;
    assign in_win     = (state == ST_MEASURE) || (state == ST_LOCKED);
    assign win_end    = in_win && (win_cnt == WW'(WIN_CYC - 1));
    // The edge seen on the window's last cycle still belongs to that window
    assign cnt_fin    = (edge_det && (edge_cnt != {CW{1'b1}})) ? edge_cnt + 1'b1 : edge_cnt;
    assign diff       = $signed({1'b0, cnt_fin}) - $signed({1'b0, exp_q});
    assign mag        = diff[CW] ? (~diff + 1'b1) : diff;
    assign good       = mag <= (CW+1)'(TOL);
    assign good_last  = good_run == GW'(GOOD_REQ - 1);
    assign bad_last   = bad_run == BW'(BAD_REQ - 1);
    assign retry_last = retry_cnt == 2'(RETRY_MAX - 1);

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   state_nxt = ST_RESET;
                ST_RESET:  if (seq_cnt == TW'(RST_CYC - 1)) state_nxt = ST_SETTLE;
                ST_SETTLE: if (seq_cnt == TW'(SETTLE_CYC - 1)) state_nxt = ST_MEASURE;
                ST_MEASURE: begin
                    if (win_end) begin
                        if (good) begin
                            if (good_last) state_nxt = ST_LOCKED;
                        end else begin
                            state_nxt = retry_last ? ST_FAULT : ST_RESET;
                        end
                    end
                end
                ST_LOCKED: if (win_end && !good && bad_last) state_nxt = ST_RESET;
                ST_FAULT:  state_nxt = ST_FAULT;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            seq_cnt   <= '0;
            win_cnt   <= '0;
            edge_cnt  <= '0;
            exp_q     <= '0;
            good_run  <= '0;
            bad_run   <= '0;
            meas_cnt  <= '0;
            retry_cnt <= '0;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
        end else begin
            state <= state_nxt;
            sync1 <= fb_tgl;
            sync2 <= sync1;
            sync3 <= sync2;

            if (((state == ST_RESET) || (state == ST_SETTLE)) && (state_nxt == state))
                seq_cnt <= seq_cnt + 1'b1;
            else
                seq_cnt <= '0;

            if (state == ST_RESET && state_nxt == ST_SETTLE)
                exp_q <= exp_cnt;

            // Windows run back-to-back from MEASURE entry through LOCKED
            if (in_win) begin
                if (win_end) begin
                    win_cnt  <= '0;
                    edge_cnt <= '0;
                    meas_cnt <= cnt_fin;
                end else begin
                    win_cnt  <= win_cnt + 1'b1;
                    edge_cnt <= cnt_fin;
                end
            end else begin
                win_cnt  <= '0;
                edge_cnt <= '0;
            end

            if (state != ST_MEASURE)
                good_run <= '0;
            else if (win_end && good)
                good_run <= good_last ? '0 : good_run + 1'b1;

            if (state != ST_LOCKED)
                bad_run <= '0;
            else if (win_end)
                bad_run <= (good || bad_last) ? '0 : bad_run + 1'b1;

            if (state == ST_MEASURE && win_end) begin
                if (!good)
                    retry_cnt <= retry_cnt + 1'b1;
                else if (good_last)
                    retry_cnt <= '0;
            end

            if (!en) begin
                retry_cnt <= '0;
                meas_cnt  <= '0;
            end
        end
    end

    assign pll_rst = (state == ST_IDLE) || (state == ST_RESET) || (state == ST_FAULT);
    assign locked  = state == ST_LOCKED;
    assign fault   = state == ST_FAULT;
    assign busy    = (state == ST_RESET) || (state == ST_SETTLE) || (state == ST_MEASURE);

`ifdef PLL_LOCK_SEQ_IRQ_EN
    logic irq_set;

    // Looking at the next state makes irq rise together with the status change
    assign irq_set = ((state_nxt == ST_LOCKED) != locked) ||
                     ((state_nxt == ST_FAULT) && !fault);

    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst)
            irq <= 1'b0;
        else if (irq_set)
            irq <= 1'b1;
        else if (irq_clr)
            irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// tb/tb_pll_lock_seq.sv - directed self-checking bench for pll_lock_seq
module tb_pll_lock_seq;

    logic       ref_clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] exp_cnt = 8'd16;
    logic       fb_tgl = 1'b0;
    logic       pll_rst;
    logic       locked;
    logic       fault;
    logic       busy;
    logic [7:0] meas_cnt;
    logic [1:0] retry_cnt;
`ifdef PLL_LOCK_SEQ_IRQ_EN
    logic       irq;
    logic       irq_clr = 1'b0;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int edge_no = 0;
    int n_per_win = 0;
    int ph = 0;

    pll_lock_seq dut (
        .ref_clk   (ref_clk),
        .rst       (rst),
        .en        (en),
        .exp_cnt   (exp_cnt),
        .fb_tgl    (fb_tgl),
        .pll_rst   (pll_rst),
        .locked    (locked),
        .fault     (fault),
        .busy      (busy),
        .meas_cnt  (meas_cnt),
        .retry_cnt (retry_cnt)
`ifdef PLL_LOCK_SEQ_IRQ_EN
        ,
        .irq       (irq),
        .irq_clr   (irq_clr)
`endif
    );

    always #5 ref_clk = ~ref_clk;

    // Toggle positions repeat every 64 cycles, so any 64-cycle window sees exactly n_per_win edges
    initial forever begin
        @(negedge ref_clk);
        if ((((ph + 1) * n_per_win) / 64) != ((ph * n_per_win) / 64))
            fb_tgl = ~fb_tgl;
        ph = (ph + 1) % 64;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycle n is the ref_clk period that follows edge n-1; edge 0 samples en=1
    task automatic at_cycle(input int n);
        if (edge_no < n - 1) begin
            while (edge_no < n - 1) begin
                @(posedge ref_clk);
                edge_no++;
            end
            #2;
        end
    endtask

    task automatic start_seq();
        en = 1'b1;
        @(posedge ref_clk);
        edge_no = 0;
        #2;
    endtask

    task automatic stop_seq();
        en = 1'b0;
        @(posedge ref_clk);
        #2;
    endtask

    initial begin
        #1;
        check("rst_pll_rst", pll_rst, 1);
        check("rst_locked", locked, 0);
        check("rst_fault", fault, 0);
        check("rst_busy", busy, 0);
        check("rst_meas_cnt", meas_cnt, 0);
        check("rst_retry_cnt", retry_cnt, 0);
        repeat (2) @(negedge ref_clk);
        rst = 1'b0;
        @(posedge ref_clk);
        #2;

        // Nominal lock at 16 edges per window
        n_per_win = 16;
        start_seq();
        check("lock_c1_pll_rst", pll_rst, 1);
        check("lock_c1_busy", busy, 1);
        at_cycle(16);
        check("lock_c16_pll_rst", pll_rst, 1);
        at_cycle(17);
        check("lock_c17_pll_rst", pll_rst, 0);
        at_cycle(528);
        check("lock_c528_locked", locked, 0);
        at_cycle(529);
        check("lock_c529_locked", locked, 1);
        check("lock_meas_cnt", meas_cnt, 16);
        check("lock_retry_cnt", retry_cnt, 0);
        check("lock_busy", busy, 0);
`ifdef PLL_LOCK_SEQ_IRQ_EN
        check("irq_on_lock", irq, 1);
        irq_clr = 1'b1;
        at_cycle(530);
        irq_clr = 1'b0;
        check("irq_cleared", irq, 0);
`endif
        stop_seq();

        // Deviation of 2 is still good
        n_per_win = 18;
        start_seq();
        at_cycle(529);
        check("tol18_locked", locked, 1);
        check("tol18_meas_cnt", meas_cnt, 18);
        stop_seq();

        // Deviation of 3 fails the first window
        n_per_win = 19;
        start_seq();
        at_cycle(336);
        check("tol19_c336_pll_rst", pll_rst, 0);
        check("tol19_c336_retry", retry_cnt, 0);
        at_cycle(337);
        check("tol19_c337_pll_rst", pll_rst, 1);
        check("tol19_retry", retry_cnt, 1);
        check("tol19_meas_cnt", meas_cnt, 19);
        check("tol19_locked", locked, 0);
        at_cycle(352);
        check("tol19_c352_pll_rst", pll_rst, 1);
        at_cycle(353);
        check("tol19_c353_pll_rst", pll_rst, 0);
        stop_seq();

        // Loss of lock after two bad windows, then relock
        n_per_win = 16;
        start_seq();
        at_cycle(529);
        check("loss_pre_locked", locked, 1);
        n_per_win = 0;
`ifdef PLL_LOCK_SEQ_IRQ_EN
        at_cycle(600);
        irq_clr = 1'b1;
        at_cycle(601);
        irq_clr = 1'b0;
        check("irq_cleared_locked", irq, 0);
`endif
        at_cycle(656);
        check("loss_c656_locked", locked, 1);
`ifdef PLL_LOCK_SEQ_IRQ_EN
        irq_clr = 1'b1;
`endif
        at_cycle(657);
`ifdef PLL_LOCK_SEQ_IRQ_EN
        irq_clr = 1'b0;
        check("irq_set_wins", irq, 1);
`endif
        check("loss_c657_locked", locked, 0);
        check("loss_c657_pll_rst", pll_rst, 1);
        check("loss_retry_cnt", retry_cnt, 0);
        n_per_win = 16;
        at_cycle(672);
        check("loss_c672_pll_rst", pll_rst, 1);
        at_cycle(673);
        check("loss_c673_pll_rst", pll_rst, 0);
        at_cycle(1184);
        check("relock_c1184_locked", locked, 0);
        at_cycle(1185);
        check("relock_c1185_locked", locked, 1);
        stop_seq();

        // Static feedback exhausts three attempts
        n_per_win = 0;
        start_seq();
        at_cycle(1008);
        check("fault_c1008_fault", fault, 0);
        check("fault_c1008_retry", retry_cnt, 2);
        at_cycle(1009);
        check("fault_c1009_fault", fault, 1);
        check("fault_pll_rst", pll_rst, 1);
        check("fault_retry", retry_cnt, 3);
        check("fault_busy", busy, 0);
        en = 1'b0;
        at_cycle(1010);
        check("fault_drop_fault", fault, 0);
        check("fault_drop_retry", retry_cnt, 0);

        // Asynchronous reset mid-MEASURE
        n_per_win = 16;
        start_seq();
        at_cycle(400);
        check("arst_pre_meas_cnt", meas_cnt, 16);
        check("arst_pre_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("arst_pll_rst", pll_rst, 1);
        check("arst_busy", busy, 0);
        check("arst_meas_cnt", meas_cnt, 0);
        #1 rst = 1'b0;
        start_seq();
        at_cycle(528);
        check("arst_c528_locked", locked, 0);
        at_cycle(529);
        check("arst_c529_locked", locked, 1);
        check("arst_meas_cnt_lock", meas_cnt, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_seq.md
Name: pll_lock_seq

Overview:
- Sequencer and lock monitor for the PLL.
- Drives the PLL reset, waits for settling, then measures the PLL feedback frequency against an expected count over fixed windows of ref_clk cycles.
- Declares lock, detects loss of lock, retries relock, and flags a permanent fault.
- Sits beside the pll instance in the ref_clk domain; the PLL supplies a slow feedback toggle (fb_tgl) derived from out_clk.

Parameters:
- WIN_CYC, 64: measurement window length in ref_clk cycles.
- CW, 8: width of the edge counter, exp_cnt and meas_cnt.
- TOL, 2: allowed absolute deviation |count - exp_cnt| for a good window.
- RST_CYC, 16: ref_clk cycles that pll_rst is held during the RESET state.
- SETTLE_CYC, 256: ref_clk cycles spent in SETTLE before measuring.
- GOOD_REQ, 4: consecutive good windows required to declare lock.
- BAD_REQ, 2: consecutive bad windows in LOCKED that declare loss of lock.
- RETRY_MAX, 3: failed lock attempts before FAULT.

Ports:
- ref_clk, in, 1: sole clock.
- rst, in, 1: asynchronous reset, active-high.
- en, in, 1: sequencer enable (level).
- exp_cnt, in, CW: expected fb_tgl edges per window.
- fb_tgl, in, 1: PLL feedback toggle, asynchronous to ref_clk; toggle rate below ref_clk/4.
- pll_rst, out, 1: PLL reset, active-high.
- locked, out, 1: lock status.
- fault, out, 1: lock attempts exhausted.
- busy, out, 1: high in RESET, SETTLE or MEASURE.
- meas_cnt, out, CW: edge count of the last completed window.
- retry_cnt, out, 2: failed attempts since the last lock.

Behaviour:
- Reset is asynchronous and active-high; clock and reset ports are ref_clk and rst. All flops reset.
- Output reset values: pll_rst=1, locked=0, fault=0, busy=0, meas_cnt=0, retry_cnt=0; state=IDLE.
- fb_tgl synchronizer: 2-flop synchronizer (reset 0), plus one delay flop.
  - An edge is either transition of the synchronized signal; latency is 3 cycles.
  - Edges are counted only inside MEASURE/LOCKED windows.
- Edge counter saturates at 2^CW-1 and clears at window start.
- Window end (every WIN_CYC cycles):
  - meas_cnt is loaded, visible the next cycle.
  - The window is good iff |count - exp_cnt| <= TOL, computed in CW+1 bits signed with no wrap.
- exp_cnt is sampled on entry to SETTLE and held until the next SETTLE entry.
- States:
  - IDLE: pll_rst=1. If en=1, go to RESET.
  - RESET: pll_rst=1 for RST_CYC cycles, then SETTLE. pll_rst=0 from SETTLE onward.
  - SETTLE: count SETTLE_CYC cycles, then MEASURE (first window starts on entry).
  - MEASURE:
    - good window: good_run++. When good_run reaches GOOD_REQ, go to LOCKED; locked=1 from the first cycle in LOCKED, and retry_cnt clears.
    - bad window: retry_cnt++. If retry_cnt reaches RETRY_MAX, go to FAULT, else go to RESET.
  - LOCKED:
    - Windows continue back-to-back.
    - A bad window increments bad_run; a good window clears it.
    - When bad_run reaches BAD_REQ: locked=0 and go to RESET (relock); retry_cnt is unchanged.
  - FAULT: pll_rst=1, fault=1, held until en=0.
- en=0 in any state: next cycle state=IDLE, pll_rst=1, locked=0, fault=0, retry_cnt=0, counters cleared.
- en re-asserted while in IDLE starts a full sequence.
- rst mid-operation: all outputs return to reset values immediately (asynchronous); the sequence restarts only after rst=0 and en=1.
- Timing from the edge that samples en=1 (cycle 0), with defaults:
  - RESET: cycles 1-16.
  - SETTLE: cycles 17-272.
  - Windows: 273-336, 337-400, 401-464, 465-528.
  - locked=1 at cycle 529 if all four windows are good.

Optional Feature:
- Macro: PLL_LOCK_SEQ_IRQ_EN.
- Defined:
  - Adds port irq (out, 1) and port irq_clr (in, 1).
  - irq is set on any locked 0->1 or 1->0 transition, or on fault 0->1.
  - irq stays set until irq_clr=1 is sampled. If set and clear occur in the same cycle, set wins.
  - irq resets to 0.
- Undefined: neither port exists, and core behaviour is identical.

Test Plan:
- Lock: en=1, exp_cnt=16, fb_tgl toggling every 4 cycles -> pll_rst=1 cycles 1-16, locked=1 at cycle 529, meas_cnt=16, retry_cnt=0.
- Tolerance: exp_cnt=16 with 18 edges/window -> locks. With 19 edges/window -> first window bad, retry_cnt=1, pll_rst re-asserted for 16 cycles.
- Loss of lock: locked, then fb_tgl held constant -> after 2 windows (128 cycles) locked=0, pll_rst=1 for 16 cycles, then relock once toggling resumes.
- Fault: fb_tgl static, exp_cnt=16 -> 3 failed attempts, then fault=1, pll_rst=1, retry_cnt=3. Drop en -> fault=0 and retry_cnt=0 next cycle.
- Reset: rst=1 mid-MEASURE -> pll_rst=1, busy=0, meas_cnt=0 without a clock edge. After release with en=1, the full sequence runs with lock at cycle 529.
- IRQ (macro defined): lock event -> irq=1. irq_clr pulse -> irq=0. Loss of lock coinciding with irq_clr -> irq stays 1.
